// File: rtl/lunar_lander_core.sv
// Lunar lander engine: BCD ten's-complement flight physics on one clock with an
// internal tick divider, pushbutton decode and a sign/magnitude display value.
module lunar_lander_core #(
    parameter int unsigned         DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] FUEL_INIT   = 'h0800,
    parameter logic [4*DIGITS-1:0] ALT_INIT    = 'h4500,
    parameter logic [4*DIGITS-1:0] VEL_INIT    = 'h0000,
    parameter logic [4*DIGITS-1:0] THRUST_INIT = 'h0005,
    parameter logic [4*DIGITS-1:0] GRAV        = 'h0005,
    parameter logic [4*DIGITS-1:0] SAFE_VEL    = 'h0030,
    parameter int unsigned         TICK_DIV    = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [19:0]           in,
    output logic [4*DIGITS-1:0]   alt,
    output logic [4*DIGITS-1:0]   vel,
    output logic [4*DIGITS-1:0]   fuel,
    output logic [4*DIGITS-1:0]   thrust,
    output logic [1:0]            disp_sel,
    output logic [4*DIGITS-1:0]   disp_mag,
    output logic                  disp_neg,
    output logic                  step,
    output logic                  paused,
    output logic                  land,
    output logic                  crash
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {FLY, PAUSE, UPDATE, CHECK, HALT} state_t;

    function automatic logic [W-1:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
        logic [W-1:0] r;
        logic         c;
        logic [4:0]   s;
        r = '0;
        c = cin;
        for (int i = 0; i < int'(DIGITS); i++) begin
            s = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(c);
            if (s > 5'd9) begin
                r[4*i +: 4] = 4'(s - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        return r;
    endfunction

    // a - b as a + nines(b) + 1
    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] n;
        for (int i = 0; i < int'(DIGITS); i++) n[4*i +: 4] = 4'(4'd9 - b[4*i +: 4]);
        return bcd_add(a, n, 1'b1);
    endfunction

    function automatic logic is_neg(input logic [W-1:0] x);
        return x[W-1 -: 4] >= 4'd5;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    thrust_req_q, req_d;
    logic [W-1:0]    alt_d, vel_d, fuel_d, thrust_d;
    logic [1:0]      sel_d;
    logic            step_d, land_d, crash_d;
    logic [2:0]      key_hist_q;
    logic [4:0]      code_c, code1_q, code2_q;
    logic            press_c;
    logic [W-1:0]    alt_sum_c, vel_next_c, fuel_diff_c, vel_mag_c, sel_val_c;
    logic            fuel_short_c;

    // OR-encode of every asserted key
    always_comb begin
        code_c = '0;
        for (int i = 0; i < 20; i++) begin
            if (in[i]) code_c = code_c | 5'(i);
        end
    end

    assign press_c      = key_hist_q[1] & ~key_hist_q[2];
    assign alt_sum_c    = bcd_add(alt, vel, 1'b0);
    assign vel_next_c   = bcd_add(bcd_sub(vel, GRAV), thrust, 1'b0);
    assign fuel_diff_c  = bcd_sub(fuel, thrust);
    assign fuel_short_c = is_neg(fuel_diff_c);
    assign vel_mag_c    = is_neg(vel) ? bcd_sub('0, vel) : vel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FLY;
            cnt_q        <= '0;
            alt          <= ALT_INIT;
            vel          <= VEL_INIT;
            fuel         <= FUEL_INIT;
            thrust       <= THRUST_INIT;
            thrust_req_q <= THRUST_INIT;
            disp_sel     <= '0;
            step         <= 1'b0;
            paused       <= 1'b0;
            land         <= 1'b0;
            crash        <= 1'b0;
            key_hist_q   <= '0;
            code1_q      <= '0;
            code2_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alt          <= alt_d;
            vel          <= vel_d;
            fuel         <= fuel_d;
            thrust       <= thrust_d;
            thrust_req_q <= req_d;
            disp_sel     <= sel_d;
            step         <= step_d;
            paused       <= (state_d == PAUSE);
            land         <= land_d;
            crash        <= crash_d;
            key_hist_q   <= {key_hist_q[1:0], |in};
            code1_q      <= code_c;
            code2_q      <= code1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alt_d    = alt;
        vel_d    = vel;
        fuel_d   = fuel;
        thrust_d = thrust;
        req_d    = thrust_req_q;
        sel_d    = disp_sel;
        step_d   = 1'b0;
        land_d   = land;
        crash_d  = crash;

        if (press_c && code2_q <= 5'd9) req_d = W'(code2_q[3:0]);
        if (press_c && code2_q >= 5'd16 && code2_q <= 5'd19) sel_d = 2'(5'd19 - code2_q);

        case (state_q)
            FLY: begin
                // pause wins over the tick so the held count resumes intact
                if (press_c && code2_q == 5'd10) begin
                    state_d = PAUSE;
                end else if (cnt_q == CW'(TICK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = UPDATE;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAUSE: begin
                if (press_c && code2_q == 5'd10) state_d = FLY;
            end
            UPDATE: begin
                alt_d    = alt_sum_c;
                vel_d    = vel_next_c;
                fuel_d   = fuel_short_c ? '0 : fuel_diff_c;
                thrust_d = (fuel == '0 || fuel_short_c) ? '0 : thrust_req_q;
                state_d  = CHECK;
            end
            CHECK: begin
                if (is_neg(alt)) begin
                    if (vel_mag_c <= SAFE_VEL) land_d = 1'b1;
                    else crash_d = 1'b1;
                    alt_d   = '0;
                    vel_d   = '0;
                    state_d = HALT;
                end else begin
                    state_d = FLY;
                end
            end
            HALT: begin
                alt_d = '0;
                vel_d = '0;
                if (press_c && code2_q == 5'd11) begin
                    alt_d    = ALT_INIT;
                    vel_d    = VEL_INIT;
                    fuel_d   = FUEL_INIT;
                    thrust_d = THRUST_INIT;
                    req_d    = THRUST_INIT;
                    land_d   = 1'b0;
                    crash_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = FLY;
                end
            end
            default: state_d = FLY;
        endcase
    end

    // display value in sign/magnitude form
    always_comb begin
        case (disp_sel)
            2'd0:    sel_val_c = alt;
            2'd1:    sel_val_c = vel;
            2'd2:    sel_val_c = fuel;
            default: sel_val_c = thrust;
        endcase
    end

    assign disp_neg = is_neg(sel_val_c);
    assign disp_mag = disp_neg ? bcd_sub('0, sel_val_c) : sel_val_c;

endmodule

// File: tb/tb_lunar_lander_core.sv
// Bench for lunar_lander_core: four differently parameterised instances checked
// against an integer-arithmetic model of the lander rules.
module tb_lunar_lander_core;
    localparam int MODV = 10000;
    localparam int GRAVI = 5;
    localparam int SAFEI = 30;
    localparam int TDIV = 25;
    localparam int S_FLY = 0, S_PAUSE = 1, S_UPDATE = 2, S_CHECK = 3, S_HALT = 4;

    typedef logic [86:0] vec_t;

    logic clk;
    logic rst [4];
    logic [19:0] keys [4];
    logic [15:0] o_alt [4], o_vel [4], o_fuel [4], o_thr [4], o_mag [4];
    logic [1:0]  o_sel [4];
    logic o_neg [4], o_step [4], o_paused [4], o_land [4], o_crash [4];

    int n_checks = 0;
    int n_errors = 0;

    int p_fuel [4] = '{800, 12, 800, 800};
    int p_alt  [4] = '{4500, 4500, 10, 10};
    int p_vel  [4] = '{0, 0, 0, 9950};
    int p_thr  [4] = '{5, 5, 0, 0};

    int m_alt [4], m_vel [4], m_fuel [4], m_thr [4], m_req [4], m_sel [4], m_cnt [4], m_st [4];
    bit m_step [4], m_land [4], m_crash [4];
    logic [19:0] m_h1 [4], m_h2 [4], m_h3 [4];

    lunar_lander_core u_def (
        .clk(clk), .reset(rst[0]), .in(keys[0]), .alt(o_alt[0]), .vel(o_vel[0]), .fuel(o_fuel[0]),
        .thrust(o_thr[0]), .disp_sel(o_sel[0]), .disp_mag(o_mag[0]), .disp_neg(o_neg[0]),
        .step(o_step[0]), .paused(o_paused[0]), .land(o_land[0]), .crash(o_crash[0]));

    lunar_lander_core #(.FUEL_INIT(16'h0012)) u_fuel (
        .clk(clk), .reset(rst[1]), .in(keys[1]), .alt(o_alt[1]), .vel(o_vel[1]), .fuel(o_fuel[1]),
        .thrust(o_thr[1]), .disp_sel(o_sel[1]), .disp_mag(o_mag[1]), .disp_neg(o_neg[1]),
        .step(o_step[1]), .paused(o_paused[1]), .land(o_land[1]), .crash(o_crash[1]));

    lunar_lander_core #(.ALT_INIT(16'h0010), .THRUST_INIT(16'h0000)) u_land (
        .clk(clk), .reset(rst[2]), .in(keys[2]), .alt(o_alt[2]), .vel(o_vel[2]), .fuel(o_fuel[2]),
        .thrust(o_thr[2]), .disp_sel(o_sel[2]), .disp_mag(o_mag[2]), .disp_neg(o_neg[2]),
        .step(o_step[2]), .paused(o_paused[2]), .land(o_land[2]), .crash(o_crash[2]));

    lunar_lander_core #(.ALT_INIT(16'h0010), .VEL_INIT(16'h9950), .THRUST_INIT(16'h0000)) u_crash (
        .clk(clk), .reset(rst[3]), .in(keys[3]), .alt(o_alt[3]), .vel(o_vel[3]), .fuel(o_fuel[3]),
        .thrust(o_thr[3]), .disp_sel(o_sel[3]), .disp_mag(o_mag[3]), .disp_neg(o_neg[3]),
        .step(o_step[3]), .paused(o_paused[3]), .land(o_land[3]), .crash(o_crash[3]));

    always #5 clk = ~clk;

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Lander rules in plain decimal: negative means value >= 5000 (mod 10000)
    function automatic void model_step(input int m);
        int code, old_req, old_fuel, f, av;
        bit press;
        if (rst[m]) begin
            m_alt[m] = p_alt[m]; m_vel[m] = p_vel[m]; m_fuel[m] = p_fuel[m];
            m_thr[m] = p_thr[m]; m_req[m] = p_thr[m];
            m_sel[m] = 0; m_cnt[m] = 0; m_st[m] = S_FLY;
            m_step[m] = 0; m_land[m] = 0; m_crash[m] = 0;
            m_h1[m] = '0; m_h2[m] = '0; m_h3[m] = '0;
            return;
        end
        press = (m_h2[m] != 0) && (m_h3[m] == 0);
        code = 0;
        for (int i = 0; i < 20; i++) if (m_h2[m][i]) code = code | i;
        m_h3[m] = m_h2[m]; m_h2[m] = m_h1[m]; m_h1[m] = keys[m];
        old_req = m_req[m];
        m_step[m] = 0;
        if (press && code <= 9) m_req[m] = code;
        if (press && code >= 16 && code <= 19) m_sel[m] = 19 - code;
        case (m_st[m])
            S_FLY: begin
                if (press && code == 10) m_st[m] = S_PAUSE;
                else if (m_cnt[m] == TDIV - 1) begin
                    m_cnt[m] = 0; m_st[m] = S_UPDATE; m_step[m] = 1;
                end else m_cnt[m]++;
            end
            S_PAUSE: if (press && code == 10) m_st[m] = S_FLY;
            S_UPDATE: begin
                old_fuel = m_fuel[m];
                f = old_fuel - m_thr[m];
                m_alt[m] = (m_alt[m] + m_vel[m]) % MODV;
                m_vel[m] = (m_vel[m] + MODV - GRAVI + m_thr[m]) % MODV;
                m_fuel[m] = (f < 0) ? 0 : f;
                m_thr[m] = (old_fuel == 0 || f < 0) ? 0 : old_req;
                m_st[m] = S_CHECK;
            end
            S_CHECK: begin
                if (m_alt[m] >= 5000) begin
                    av = (m_vel[m] >= 5000) ? MODV - m_vel[m] : m_vel[m];
                    if (av <= SAFEI) m_land[m] = 1; else m_crash[m] = 1;
                    m_alt[m] = 0; m_vel[m] = 0; m_st[m] = S_HALT;
                end else m_st[m] = S_FLY;
            end
            default: begin
                m_alt[m] = 0; m_vel[m] = 0;
                if (press && code == 11) begin
                    m_alt[m] = p_alt[m]; m_vel[m] = p_vel[m]; m_fuel[m] = p_fuel[m];
                    m_thr[m] = p_thr[m]; m_req[m] = p_thr[m];
                    m_land[m] = 0; m_crash[m] = 0; m_cnt[m] = 0; m_st[m] = S_FLY;
                end
            end
        endcase
    endfunction

    always @(posedge clk) for (int m = 0; m < 4; m++) model_step(m);

    function automatic vec_t exp_vec(input int m);
        int v;
        bit n;
        case (m_sel[m])
            0: v = m_alt[m];
            1: v = m_vel[m];
            2: v = m_fuel[m];
            default: v = m_thr[m];
        endcase
        n = (v >= 5000);
        return {int2bcd(m_alt[m]), int2bcd(m_vel[m]), int2bcd(m_fuel[m]), int2bcd(m_thr[m]),
                2'(m_sel[m]), int2bcd(n ? (MODV - v) % MODV : v), n, m_step[m],
                m_st[m] == S_PAUSE, m_land[m], m_crash[m]};
    endfunction

    function automatic vec_t dut_vec(input int m);
        return {o_alt[m], o_vel[m], o_fuel[m], o_thr[m], o_sel[m], o_mag[m], o_neg[m],
                o_step[m], o_paused[m], o_land[m], o_crash[m]};
    endfunction

    function automatic vec_t reset_vec(input int m);
        return {int2bcd(p_alt[m]), int2bcd(p_vel[m]), int2bcd(p_fuel[m]), int2bcd(p_thr[m]),
                2'b00, int2bcd(p_alt[m]), 1'b0, 4'b0000};
    endfunction

    task automatic pulse_reset(input int m);
        rst[m] = 1'b1;
        @(negedge clk);
        rst[m] = 1'b0;
    endtask

    task automatic hold_key(input int m, input int code, input int n);
        keys[m] = 20'd1 << code;
        repeat (n) @(negedge clk);
        keys[m] = '0;
    endtask

    task automatic wait_step(input int m, output bit ok);
        int n;
        n = 0;
        while (o_step[m] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (o_step[m] === 1'b1);
    endtask

    task automatic test_reset;
        for (int m = 0; m < 4; m++) rst[m] = 1'b1;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (dut_vec(m) !== reset_vec(m)) begin
                n_errors++;
                $display("FAIL reset[%0d]: got %h want %h", m, dut_vec(m), reset_vec(m));
            end
        end
        for (int m = 0; m < 4; m++) rst[m] = 1'b0;
    endtask

    task automatic test_thrust_key;
        logic [15:0] ea [3] = '{16'h4500, 16'h4500, 16'h4495};
        logic [15:0] ev [3] = '{16'h0000, 16'h9995, 16'h9990};
        bit ok;
        pulse_reset(0);
        hold_key(0, 0, 3);
        for (int k = 0; k < 3; k++) begin
            wait_step(0, ok);
            @(negedge clk);
            n_checks++;
            if (!ok || {o_alt[0], o_vel[0], o_fuel[0], o_thr[0]} !== {ea[k], ev[k], 16'h0795, 16'h0000}) begin
                n_errors++;
                $display("FAIL thrust_tick%0d: got %h %h %h %h want %h %h 0795 0000 (step seen %0d)",
                         k + 1, o_alt[0], o_vel[0], o_fuel[0], o_thr[0], ea[k], ev[k], ok);
            end
        end
        hold_key(0, 18, 2);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_sel[0], o_neg[0], o_mag[0]} !== {2'd1, 1'b1, 16'h0010} || dut_vec(0) !== exp_vec(0)) begin
            n_errors++;
            $display("FAIL disp_vel: got sel %0d neg %0d mag %h want sel 1 neg 1 mag 0010",
                     o_sel[0], o_neg[0], o_mag[0]);
        end
    endtask

    task automatic test_fuel;
        logic [15:0] ef [4] = '{16'h0007, 16'h0002, 16'h0000, 16'h0000};
        logic [15:0] et [4] = '{16'h0005, 16'h0005, 16'h0000, 16'h0000};
        bit ok;
        pulse_reset(1);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) hold_key(1, 9, 2);
            wait_step(1, ok);
            @(negedge clk);
            n_checks++;
            if (!ok || {o_fuel[1], o_thr[1]} !== {ef[k], et[k]} || dut_vec(1) !== exp_vec(1)) begin
                n_errors++;
                $display("FAIL fuel_tick%0d: got fuel %h thrust %h want fuel %h thrust %h (step seen %0d)",
                         k + 1, o_fuel[1], o_thr[1], ef[k], et[k], ok);
            end
        end
    endtask

    task automatic test_land;
        bit ok, saw_step;
        pulse_reset(2);
        for (int k = 0; k < 3; k++) begin
            wait_step(2, ok);
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (!ok || {o_alt[2], o_vel[2]} !== {16'h0005, 16'h9990}) begin
                    n_errors++;
                    $display("FAIL land_tick2: got %h %h want 0005 9990", o_alt[2], o_vel[2]);
                end
            end
        end
        n_checks++;
        if ({o_alt[2], o_vel[2], o_land[2]} !== {16'h9995, 16'h9985, 1'b0}) begin
            n_errors++;
            $display("FAIL land_tick3: got %h %h land %0d want 9995 9985 land 0", o_alt[2], o_vel[2], o_land[2]);
        end
        @(negedge clk);
        n_checks++;
        if ({o_land[2], o_crash[2], o_alt[2], o_vel[2]} !== {1'b1, 1'b0, 32'h0} || dut_vec(2) !== exp_vec(2)) begin
            n_errors++;
            $display("FAIL land_flag: got land %0d crash %0d alt %h vel %h want 1 0 0000 0000",
                     o_land[2], o_crash[2], o_alt[2], o_vel[2]);
        end
        saw_step = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_step[2] === 1'b1 || o_alt[2] !== 16'h0 || o_land[2] !== 1'b1) saw_step = 1;
        end
        n_checks++;
        if (saw_step) begin
            n_errors++;
            $display("FAIL land_halt: got activity in HALT want none (land %0d alt %h)", o_land[2], o_alt[2]);
        end
    endtask

    task automatic test_crash_restart;
        bit ok;
        pulse_reset(3);
        wait_step(3, ok);
        @(negedge clk);
        n_checks++;
        if (!ok || {o_alt[3], o_vel[3]} !== {16'h9960, 16'h9945}) begin
            n_errors++;
            $display("FAIL crash_tick1: got %h %h want 9960 9945", o_alt[3], o_vel[3]);
        end
        @(negedge clk);
        n_checks++;
        if ({o_crash[3], o_land[3]} !== 2'b10) begin
            n_errors++;
            $display("FAIL crash_flag: got crash %0d land %0d want 1 0", o_crash[3], o_land[3]);
        end
        hold_key(3, 11, 2);
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_vec(3) !== reset_vec(3)) begin
            n_errors++;
            $display("FAIL restart: got %h want %h", dut_vec(3), reset_vec(3));
        end
        wait_step(3, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL restart_fly: got no step want step within 100 clks");
        end
    endtask

    task automatic test_pause;
        bit bad;
        int n;
        pulse_reset(0);
        repeat (10) @(negedge clk);
        keys[0] = 20'd1 << 10;
        repeat (3) @(negedge clk);
        keys[0] = '0;
        n_checks++;
        if (o_paused[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL pause_on: got paused %0d want 1", o_paused[0]);
        end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_step[0] !== 1'b0 || o_paused[0] !== 1'b1 ||
                {o_alt[0], o_vel[0], o_fuel[0], o_thr[0]} !== {16'h4500, 16'h0000, 16'h0800, 16'h0005})
                bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL pause_hold: got change while paused want frozen state");
        end
        keys[0] = 20'd1 << 10;
        n = 0;
        while (o_step[0] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 3) keys[0] = '0;
        end
        keys[0] = '0;
        n_checks++;
        if (n != 16 || o_paused[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL pause_resume: got step %0d clks after key want 16 (paused %0d)", n, o_paused[0]);
        end
    endtask

    task automatic test_reset_mid_update;
        bit ok;
        pulse_reset(0);
        wait_step(0, ok);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        n_checks++;
        if (!ok || dut_vec(0) !== reset_vec(0)) begin
            n_errors++;
            $display("FAIL reset_update: got %h want %h (step seen %0d)", dut_vec(0), reset_vec(0), ok);
        end
    endtask

    task automatic test_random;
        int r;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                n_checks++;
                if (dut_vec(m) !== exp_vec(m)) begin
                    n_errors++;
                    $display("FAIL random[%0d] cyc %0d: got %h want %h", m, cyc, dut_vec(m), exp_vec(m));
                end
                rst[m] = ($urandom_range(0, 999) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    r = $urandom_range(0, 9);
                    if (r < 7) keys[m] = 20'd1 << $urandom_range(0, 19);
                    else if (r == 7) keys[m] = '0;
                    else keys[m] = 20'($urandom);
                end
            end
        end
        for (int m = 0; m < 4; m++) begin
            rst[m] = 1'b0;
            keys[m] = '0;
        end
    endtask

    initial begin
        clk = 1'b0;
        for (int m = 0; m < 4; m++) begin
            rst[m] = 1'b1;
            keys[m] = '0;
        end
        test_reset;
        test_thrust_key;
        test_fuel;
        test_land;
        test_crash_restart;
        test_pause;
        test_reset_mid_update;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
